// File: rtl/graph_edge_server.sv
// graph_edge_server: CSR adjacency-list responder. A per-node {base, degree}
// table plus a flat edge RAM are filled through the load port. They are then
// queried one node at a time, returning one successor per beat.
module graph_edge_server #(
  parameter int PARAM_NODE_IDX_WIDTH = 9,
  parameter int PARAM_COUNTER_WIDTH  = 4,
  parameter int PARAM_EDGE_DEPTH     = 2048
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            load_en,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] load_src_idx,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] load_dst_idx,
  output logic                            load_ready,
  output logic                            load_err,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [PARAM_NODE_IDX_WIDTH-1:0] node_idx,
  output logic                            edge_valid,
  input  logic                            edge_ready,
  output logic                            edge_last,
  output logic [PARAM_NODE_IDX_WIDTH-1:0] next_node_idx,
  output logic [PARAM_COUNTER_WIDTH-1:0]  next_node_counter
);

  localparam int W  = PARAM_NODE_IDX_WIDTH;
  localparam int C  = PARAM_COUNTER_WIDTH;
  localparam int AW = $clog2(PARAM_EDGE_DEPTH);
  localparam logic [AW:0]  RAM_FULL = (AW+1)'(PARAM_EDGE_DEPTH);
  localparam logic [C-1:0] MAX_DEG  = '1;

  typedef enum logic [2:0] {CLEAR, IDLE, LOOKUP, FETCH, STREAM} state_t;

  state_t state_q, state_d;

  // Storage: table entry is {base, degree}; edge RAM holds destination indices
  logic [AW+C-1:0] tbl  [0:(1<<W)-1];
  logic [W-1:0]    eram [0:PARAM_EDGE_DEPTH-1];

  // Control state
  logic [W-1:0]  clr_idx;
  logic [AW:0]   ptr;
  logic          grp_vld;
  logic [W-1:0]  last_src;
  logic [AW-1:0] cur_base;
  logic [C-1:0]  cur_deg;
  logic [W-1:0]  qnode_p0;
  logic [C-1:0]  beat_k;
  logic          zero_q;

  // Pipeline data
  logic [AW+C-1:0] ent_p1;
  logic [W-1:0]    ram_p2;
  logic [AW-1:0]   ent_base;
  logic [C-1:0]    ent_deg;

  // Combinational strobes
  logic            new_grp, full, ovf;
  logic            load_acc, load_drop;
  logic [AW-1:0]   new_base;
  logic [C-1:0]    new_deg;
  logic            tbl_we;
  logic [W-1:0]    tbl_waddr;
  logic [AW+C-1:0] tbl_wdata;
  logic            rd_en;
  logic [AW-1:0]   rd_addr;

  assign ent_base      = ent_p1[AW+C-1:C];
  assign ent_deg       = ent_p1[C-1:0];
  assign load_ready    = (state_q == IDLE);
  assign req_ready     = (state_q == IDLE);
  assign next_node_idx = (edge_valid && !zero_q) ? ram_p2 : '0;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  // Next-state, load grouping decisions, table write port and RAM read address
  always_comb begin
    state_d   = state_q;
    new_grp   = !grp_vld || (load_src_idx != last_src);
    full      = (ptr == RAM_FULL);
    ovf       = !new_grp && (cur_deg == MAX_DEG);
    new_base  = new_grp ? ptr[AW-1:0] : cur_base;
    new_deg   = new_grp ? C'(1) : cur_deg + C'(1);
    load_acc  = 1'b0;
    load_drop = 1'b0;
    tbl_we    = 1'b0;
    tbl_waddr = clr_idx;
    tbl_wdata = '0;
    rd_en     = 1'b0;
    rd_addr   = ent_base;
    case (state_q)
      CLEAR: begin
        tbl_we = 1'b1;
        if (clr_idx == '1) state_d = IDLE;
      end
      IDLE: begin
        if (req_valid) begin
          state_d = LOOKUP;
        end else if (load_en) begin
          if (full || ovf) begin
            load_drop = 1'b1;
          end else begin
            load_acc  = 1'b1;
            tbl_we    = 1'b1;
            tbl_waddr = load_src_idx;
            tbl_wdata = {new_base, new_deg};
          end
        end
      end
      LOOKUP: state_d = FETCH;
      FETCH: begin
        rd_en   = 1'b1;
        rd_addr = ent_base;
        state_d = STREAM;
      end
      STREAM: begin
        if (edge_ready) begin
          if (edge_last) begin
            state_d = IDLE;
          end else begin
            rd_en   = 1'b1;
            rd_addr = ent_base + AW'(beat_k) + AW'(1);
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // Table write port (sweep or load)
  always_ff @(posedge clk) begin
    if (tbl_we) tbl[tbl_waddr] <= tbl_wdata;
  end

  // Edge RAM write port
  always_ff @(posedge clk) begin
    if (load_acc) eram[ptr[AW-1:0]] <= load_dst_idx;
  end

  // p0 -> p1: table lookup of the captured node
  always_ff @(posedge clk) begin
    if (state_q == LOOKUP) ent_p1 <= tbl[qnode_p0];
  end

  // p1 -> p2: edge RAM read, first beat in FETCH then prefetch on each accepted beat
  always_ff @(posedge clk) begin
    if (rd_en) ram_p2 <= eram[rd_addr];
  end

  // Control registers: sweep counter, group tracker, request capture and beat sequencing
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clr_idx           <= '0;
      ptr               <= '0;
      grp_vld           <= 1'b0;
      last_src          <= '0;
      cur_base          <= '0;
      cur_deg           <= '0;
      qnode_p0          <= '0;
      beat_k            <= '0;
      zero_q            <= 1'b0;
      load_err          <= 1'b0;
      edge_valid        <= 1'b0;
      edge_last         <= 1'b0;
      next_node_counter <= '0;
    end else begin
      load_err <= load_drop;
      if (state_q == CLEAR) clr_idx <= clr_idx + W'(1);
      if (load_acc) begin
        ptr      <= ptr + (AW+1)'(1);
        grp_vld  <= 1'b1;
        last_src <= load_src_idx;
        cur_base <= new_base;
        cur_deg  <= new_deg;
      end
      if (state_q == IDLE && req_valid) qnode_p0 <= node_idx;
      if (state_q == FETCH) begin
        edge_valid        <= 1'b1;
        edge_last         <= (ent_deg <= C'(1));
        zero_q            <= (ent_deg == '0);
        next_node_counter <= ent_deg;
        beat_k            <= '0;
      end
      if (state_q == STREAM && edge_ready) begin
        if (edge_last) begin
          edge_valid        <= 1'b0;
          edge_last         <= 1'b0;
          zero_q            <= 1'b0;
          next_node_counter <= '0;
        end else begin
          beat_k    <= beat_k + C'(1);
          edge_last <= ((beat_k + C'(1)) == (ent_deg - C'(1)));
        end
      end
    end
  end

endmodule
